// File: rtl/w0rm_core_fetch.sv
// W0RM instruction fetch: sequential PC generator, credit-limited imem requests, in-order inst FIFO.
// Optional perf counters under `W0RM_FETCH_PERF_COUNTERS_EN.
module w0rm_core_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 16,
  parameter int FIFO_DEPTH_LOG2 = 1,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  branch_next_pc_valid,
  input  logic                  branch_flush,
  input  logic [ADDR_WIDTH-1:0] branch_next_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  fetch_fault,
  output logic [31:0]           perf_redirect_count,
  output logic [31:0]           perf_stall_count
);

  localparam int PW = FIFO_DEPTH_LOG2;
  localparam int CW = FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_RESET,
    S_RUN,
    S_FAULT
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] resp_pc_q;
  logic [CW-1:0] outstanding_q;
  logic [CW-1:0] drop_cnt_q;
  logic [CW-1:0] fifo_cnt_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [INST_WIDTH-1:0] fifo_data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_q [DEPTH];

  logic redirect;
  logic target_odd;
  logic credit_ok;
  logic req_fire;
  logic push;
  logic pop;
  logic [CW-1:0] out_next;

  assign redirect = branch_next_pc_valid | branch_flush;
  assign target_odd = branch_next_pc[0];

  // Outstanding + buffered never exceeds the FIFO depth, so pushes always fit.
  assign credit_ok = ({1'b0, outstanding_q} + {1'b0, fifo_cnt_q})
                     < (CW+1)'(DEPTH);

  assign imem_req_valid = (state_q == S_RUN) && credit_ok && !redirect;
  assign imem_addr = pc_q;
  assign req_fire = imem_req_valid && imem_req_ready;

  assign inst_valid = (fifo_cnt_q != '0);
  assign inst_data = inst_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign inst_pc = inst_valid ? fifo_pc_q[rd_ptr_q] : '0;
  assign fetch_fault = (state_q == S_FAULT);

  assign push = !redirect && imem_resp_valid && (drop_cnt_q == '0);
  assign pop = !redirect && inst_valid && inst_ready;
  assign out_next = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET: state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_RESET;
    endcase
    if (branch_next_pc_valid) begin
      state_d = target_odd ? S_FAULT : S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q <= RESET_VECTOR;
      resp_pc_q <= RESET_VECTOR;
      outstanding_q <= '0;
      drop_cnt_q <= '0;
      fifo_cnt_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      outstanding_q <= out_next;
      if (redirect) begin
        // Everything in flight, including a response landing now, is stale.
        drop_cnt_q <= out_next;
        fifo_cnt_q <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        unique case (1'b1)
          branch_next_pc_valid && !target_odd: begin
            pc_q <= branch_next_pc;
            resp_pc_q <= branch_next_pc;
          end
          branch_next_pc_valid && target_odd: begin
            pc_q <= pc_q;
          end
          default: begin
            pc_q <= resp_pc_q;
          end
        endcase
      end else begin
        if (req_fire) begin
          pc_q <= pc_q + ADDR_WIDTH'(2);
        end
        if (imem_resp_valid && (drop_cnt_q != '0)) begin
          drop_cnt_q <= drop_cnt_q - CW'(1);
        end
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PW'(1);
          resp_pc_q <= resp_pc_q + ADDR_WIDTH'(2);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
        fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= imem_resp_data;
      fifo_pc_q[wr_ptr_q] <= resp_pc_q;
    end
  end

`ifdef W0RM_FETCH_PERF_COUNTERS_EN
  logic [31:0] redir_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      redir_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (redirect) begin
        redir_cnt_q <= redir_cnt_q + 32'd1;
      end
      if ((state_q == S_RUN) && !req_fire) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign perf_redirect_count = redir_cnt_q;
  assign perf_stall_count = stall_cnt_q;
`else
  assign perf_redirect_count = '0;
  assign perf_stall_count = '0;
`endif

endmodule

// File: doc/w0rm_core_fetch.md
Name: w0rm_core_fetch

Overview:
Instruction fetch / PC generator for the W0RM core; it is the consumer of the branch unit's redirect outputs (next_pc, next_pc_valid, flush_pipeline).
- Issues sequential 16-bit instruction fetches (PC += 2) to instruction memory.
- Buffers returned instructions in a small in-order FIFO and presents them, tagged with their PC, to decode.
- On a branch redirect: discards buffered and in-flight fetches, then restarts at the target.

Parameters:
ADDR_WIDTH, 32, PC / instruction-memory address width
INST_WIDTH, 16, instruction word width
FIFO_DEPTH_LOG2, 1, log2 of the instruction buffer depth (default 2 entries); also caps outstanding requests
RESET_VECTOR, 0, PC loaded at reset

Ports:
clk  input  1  clock
reset_n  input  1  synchronous active-low reset
branch_next_pc_valid  input  1  redirect request from branch unit
branch_flush  input  1  pipeline flush from branch unit; OR'd with branch_next_pc_valid
branch_next_pc  input  ADDR_WIDTH  redirect target
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  ADDR_WIDTH  fetch address
imem_resp_valid  input  1  response valid; in order, one per accepted request, no backpressure
imem_resp_data  input  INST_WIDTH  fetched instruction
inst_valid  output  1  instruction available to decode
inst_ready  input  1  decode accepts instruction
inst_data  output  INST_WIDTH  instruction word
inst_pc  output  ADDR_WIDTH  PC of inst_data (branch_base_addr for the branch unit)
fetch_fault  output  1  misaligned redirect target seen

Behaviour:
- Reset (reset_n=0 at posedge):
  - Registers: pc=RESET_VECTOR, resp_pc=RESET_VECTOR, outstanding=0, drop_cnt=0, FIFO empty, state=S_RESET.
  - Outputs: imem_req_valid=0, imem_addr=RESET_VECTOR, inst_valid=0, inst_data=0, inst_pc=0, fetch_fault=0.
  - Reset mid-operation abandons all in-flight responses; memory is reset alongside.
- States:
  - S_RESET: one cycle, no requests, then S_RUN.
  - S_RUN: normal fetch.
  - S_FAULT: no requests, fetch_fault=1. Exit to S_RUN only on an aligned redirect, or on reset.
- Request (S_RUN):
  - imem_req_valid=1 iff outstanding + fifo_count < 2^FIFO_DEPTH_LOG2 and no redirect this cycle; imem_addr=pc.
  - On valid&&ready: pc<=pc+2 (wraps modulo 2^ADDR_WIDTH), outstanding++.
  - imem_req_valid/imem_addr are registered-stable; once asserted they do not change until accepted, except when a redirect or reset cancels them.
- Response:
  - If drop_cnt>0: discard the response, drop_cnt--, outstanding--.
  - Otherwise: push {resp_pc, imem_resp_data}, resp_pc+=2, outstanding--.
  - The credit rule guarantees the FIFO never overflows.
- Output:
  - inst_valid = FIFO non-empty; inst_data/inst_pc come from the FIFO head.
  - Pop on inst_valid&&inst_ready.
  - inst_data/inst_pc are 0 when the FIFO is empty.
  - Simultaneous push and pop on a full FIFO is legal (count unchanged).
- Redirect (branch_next_pc_valid|branch_flush at posedge); the same edge takes priority over every other update:
  - FIFO cleared; any pop that cycle is ignored.
  - drop_cnt <= outstanding + (request accepted this cycle ? 1 : 0) − (response this cycle ? 1 : 0). A response arriving in the redirect cycle is always discarded.
  - Target update:
    - branch_next_pc_valid=1, target[0]=0: pc<=resp_pc<=branch_next_pc, state=S_RUN.
    - branch_next_pc_valid=1, target[0]=1: state=S_FAULT, pc unchanged.
    - branch_flush alone: pc<=resp_pc<=resp_pc, i.e. refetch from the oldest undelivered instruction.
  - Each asserted cycle is a separate redirect; a held-high input repeats the redirect and stalls fetch.
- Latency: a redirect at edge N gives imem_req_valid=1 with the new address after edge N (first request cycle N+1). The first instruction reaches inst_valid one cycle after its response.
- Counter widths: outstanding and drop_cnt are FIFO_DEPTH_LOG2+1 bits.

Optional Feature:
- Macro W0RM_FETCH_PERF_COUNTERS_EN.
- Defined:
  - Adds outputs perf_redirect_count[31:0] (+1 per redirect cycle) and perf_stall_count[31:0] (+1 per cycle in S_RUN with imem_req_valid=0 or imem_req_ready=0).
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: the ports exist but are tied to 0, and no counter logic is built.

Test Plan:
- Reset release, imem always ready, 1-cycle response latency, inst_ready=1 → imem_addr sequence 0,2,4,6; inst_pc 0,2,4 with matching data; fetch_fault=0.
- inst_ready=0 for 10 cycles → at most 2 requests outstanding+buffered; inst_valid held with inst_pc=0 stable; no overflow; resumes in order.
- 2 requests outstanding, then branch_next_pc_valid=1 with target 0x100 → both stale responses dropped; next inst_pc=0x100, then 0x102.
- Redirect to 0x101 → S_FAULT, fetch_fault=1, imem_req_valid=0; then redirect to 0x200 → fetch_fault=0, fetching from 0x200.
- Redirect on the same edge as a response and a pop → response discarded, FIFO empty next cycle, pc=target.
- With W0RM_FETCH_PERF_COUNTERS_EN: 3 redirects and 5 forced imem_req_ready=0 cycles → perf_redirect_count=3, perf_stall_count≥5; without the macro both read 0.
